conv_formato_pipe: RTL and testbench

Pipelined, parametrised fixed-point format converter. Takes a two's-complement Q value of width WI with FI fractional bits and produces a value of width WO with FO fractional bits, aligning the binary point and sign-extending. It adds selectable rounding, overflow detection and saturation, a valid/ready handshake and an overflow event counter. It sits between arithmetic stages that use different Q formats, such as widening an N-bit sample to the 2N-bit accumulator format or narrowing an accumulator result back.

---
 rtl/conv_formato_pipe.sv | 134 +++++++++++++
 tb/tb_conv_formato_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_formato_pipe.sv
// conv_formato_pipe: pipelined Q-format converter with rounding, overflow flag and count.
// Define CONV_SAT_EN to clamp on overflow; otherwise the result wraps to the low WO bits.
module conv_formato_pipe #(
    parameter int WI = 16,
    parameter int FI = 8,
    parameter int WO = 32,
    parameter int FO = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WI-1:0] in_data,
    input  logic          mode_round,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WO-1:0] out_data,
    output logic          out_ovf,
    input  logic          clr_cnt,
    output logic [15:0]   ovf_cnt
);
    localparam int SH = (FO >= FI) ? FO - FI : FI - FO;
    localparam int WM = WI + SH + 2;
    localparam int HS = (SH > 0) ? SH - 1 : 0;
    localparam logic signed [WM-1:0] HALF =
        (FO < FI) ? (WM'(1) <<< HS) : WM'(0);

    logic                 adv;
    logic                 s1_v;
    logic signed [WM-1:0] s1_d;
    logic                 s2_v;
    logic [WO-1:0]        s2_d;
    logic                 s2_o;
    logic signed [WM-1:0] ext;
    logic signed [WM-1:0] addv;
    logic signed [WM-1:0] algn;
    logic                 ovf;
    logic [WO-1:0]        low;
    logic [WO-1:0]        res;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // S1: align binary point; internal width leaves headroom for the round add
    assign ext  = {{(WM-WI){in_data[WI-1]}}, in_data};
    assign addv = mode_round ? HALF : '0;

    always_comb begin
        algn = ext;
        if (FO >= FI) begin
            algn = ext <<< SH;
        end else begin
            algn = (ext + addv) >>> SH;
        end
    end

    // S2: out of range when the bits above the output sign are not a sign extension
    generate
        if (WM >= WO) begin : g_nar
            logic [WM-WO:0] top;
            assign top = s1_d[WM-1:WO-1];
            assign ovf = !((&top) || !(|top));
            assign low = s1_d[WO-1:0];
        end else begin : g_wid
            assign ovf = 1'b0;
            assign low = {{(WO-WM){s1_d[WM-1]}}, s1_d};
        end
    endgenerate

`ifdef CONV_SAT_EN
    localparam logic [WO-1:0] MAXV = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] MINV = {1'b1, {(WO-1){1'b0}}};
    logic s2_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_n <= 1'b0;
        end else if (adv && s1_v) begin
            s2_n <= s1_d[WM-1];
        end
    end

    always_comb begin
        res = s2_d;
        if (s2_o) begin
            res = s2_n ? MINV : MAXV;
        end
    end
`else
    always_comb begin
        res = s2_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_d      <= '0;
            s2_v      <= 1'b0;
            s2_d      <= '0;
            s2_o      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            s1_v      <= in_valid;
            s2_v      <= s1_v;
            out_valid <= s2_v;
            out_ovf   <= s2_v && s2_o;
            if (in_valid) begin
                s1_d <= algn;
            end
            if (s1_v) begin
                s2_d <= low;
                s2_o <= ovf;
            end
            if (s2_v) begin
                out_data <= res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (clr_cnt) begin
            ovf_cnt <= '0;
        end else if (out_valid && out_ready && out_ovf
                     && ovf_cnt != 16'hFFFF) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_conv_formato_pipe.sv
// tb_conv_formato_pipe: directed checks of a widening and a narrowing converter.
// Covers alignment, rounding, overflow, backpressure, reset and the counter.
module tb_conv_formato_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        w_iv, w_ir, w_mr, w_ov, w_or, w_of, w_clr;
    logic [15:0] w_id, w_cnt;
    logic [31:0] w_od;
    logic        n_iv, n_ir, n_mr, n_ov, n_or, n_of, n_clr;
    logic [15:0] n_id, n_cnt;
    logic [7:0]  n_od;

    conv_formato_pipe #(.WI(16), .FI(8), .WO(32), .FO(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .in_ready(w_ir),
        .in_data(w_id), .mode_round(w_mr), .out_valid(w_ov),
        .out_ready(w_or), .out_data(w_od), .out_ovf(w_of),
        .clr_cnt(w_clr), .ovf_cnt(w_cnt));

    conv_formato_pipe #(.WI(16), .FI(8), .WO(8), .FO(4)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(n_iv), .in_ready(n_ir),
        .in_data(n_id), .mode_round(n_mr), .out_valid(n_ov),
        .out_ready(n_or), .out_data(n_od), .out_ovf(n_of),
        .clr_cnt(n_clr), .ovf_cnt(n_cnt));

`ifdef CONV_SAT_EN
    localparam logic [31:0] E_P9 = 32'h7F;
    localparam logic [31:0] E_N9 = 32'h80;
    localparam logic [31:0] E_P8 = 32'h7F;
`else
    localparam logic [31:0] E_P9 = 32'h90;
    localparam logic [31:0] E_N9 = 32'h70;
    localparam logic [31:0] E_P8 = 32'h80;
`endif

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          nar;
        logic [15:0] din;
        bit          rnd;
        logic [31:0] dout;
        bit          ovf;
    } vec_t;

    vec_t tv[10];

    task automatic send(input bit nar, input logic [15:0] d, input bit r);
        @(posedge clk); #1;
        if (nar) begin
            n_iv = 1'b1; n_id = d; n_mr = r;
        end else begin
            w_iv = 1'b1; w_id = d; w_mr = r;
        end
        @(posedge clk); #1;
        n_iv = 1'b0;
        w_iv = 1'b0;
    endtask

    function automatic logic [31:0] wexp(input logic [15:0] d);
        return {{8{d[15]}}, d, 8'h00};
    endfunction

    logic [31:0] recv[$];
    logic [31:0] held;

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{0, 16'h0180, 0, 32'h0001_8000, 0};
        tv[1] = '{0, 16'hFE80, 0, 32'hFFFE_8000, 0};
        tv[2] = '{0, 16'hFE80, 1, 32'hFFFE_8000, 0};
        tv[3] = '{1, 16'h0118, 0, 32'h11, 0};
        tv[4] = '{1, 16'h0118, 1, 32'h12, 0};
        tv[5] = '{1, 16'hFFF8, 0, 32'hFF, 0};
        tv[6] = '{1, 16'hFFF8, 1, 32'h00, 0};
        tv[7] = '{1, 16'h0900, 0, E_P9, 1};
        tv[8] = '{1, 16'hF700, 0, E_N9, 1};
        tv[9] = '{1, 16'h07F8, 1, E_P8, 1};

        w_iv = 0; w_id = '0; w_mr = 0; w_or = 1; w_clr = 0;
        n_iv = 0; n_id = '0; n_mr = 0; n_or = 1; n_clr = 0;

        #1;
        chk("rst_in_ready", w_ir, 1);
        chk("rst_out_valid", w_ov, 0);
        chk("rst_out_data", w_od, 0);
        chk("rst_out_ovf", n_of, 0);
        chk("rst_ovf_cnt", n_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            send(tv[i].nar, tv[i].din, tv[i].rnd);
            @(posedge clk); #1;
            chk($sformatf("lat1_v%0d", i), tv[i].nar ? n_ov : w_ov, 0);
            @(posedge clk); #1;
            chk($sformatf("valid_v%0d", i), tv[i].nar ? n_ov : w_ov, 1);
            chk($sformatf("data_v%0d", i),
                tv[i].nar ? {24'h0, n_od} : w_od, tv[i].dout);
            chk($sformatf("ovf_v%0d", i), tv[i].nar ? n_of : w_of, tv[i].ovf);
        end
        @(posedge clk); #1;
        chk("cnt_after_table", n_cnt, 3);
        chk("cnt_wide", w_cnt, 0);

        send(1, 16'h0900, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("clr_word_ovf", n_of, 1);
        n_clr = 1'b1;
        @(posedge clk); #1;
        n_clr = 1'b0;
        chk("clr_priority", n_cnt, 0);

        n_iv = 1'b1; n_id = 16'h0900; n_mr = 1'b0;
        repeat (65535) @(posedge clk);
        #1 n_iv = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("cnt_reach_max", n_cnt, 16'hFFFF);
        n_iv = 1'b1;
        repeat (3) @(posedge clk);
        #1 n_iv = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("cnt_saturate", n_cnt, 16'hFFFF);

        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    w_iv = 1'b1;
                    w_id = 16'h0100 * 16'(i + 1) + 16'(i);
                    w_mr = 1'b0;
                    for (int g = 0; g < 20; g++) begin
                        @(negedge clk);
                        if (w_ir) break;
                    end
                    @(posedge clk); #1;
                end
                w_iv = 1'b0;
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (w_ov && w_or) recv.push_back(w_od);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 w_or = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    if (j == 0) begin
                        chk("stall_in_ready", w_ir, 0);
                        held = w_od;
                    end else begin
                        chk($sformatf("stall_hold%0d", j), w_od, held);
                    end
                    chk($sformatf("stall_valid%0d", j), w_ov, 1);
                    @(posedge clk);
                end
                #1 w_or = 1'b1;
            end
        join
        chk("bp_count", recv.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bp_word%0d", i),
                (i < recv.size()) ? recv[i] : 32'hDEAD_BEEF,
                wexp(16'h0100 * 16'(i + 1) + 16'(i)));
        end

        @(posedge clk); #1;
        w_iv = 1'b1; w_id = 16'h0200;
        @(posedge clk); #1 w_id = 16'h0300;
        @(posedge clk); #1 w_id = 16'h0500;
        @(posedge clk); #1 w_iv = 1'b0;
        chk("pre_rst_valid", w_ov, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", w_ov, 0);
        chk("arst_out_data", w_od, 0);
        chk("arst_ovf_cnt", n_cnt, 0);
        chk("arst_in_ready", w_ir, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        send(0, 16'h0400, 0);
        @(posedge clk); #1;
        chk("post_rst_lat1", w_ov, 0);
        @(posedge clk); #1;
        chk("post_rst_valid", w_ov, 1);
        chk("post_rst_data", w_od, 32'h0004_0000);
        @(posedge clk); #1;
        chk("post_rst_drain", w_ov, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
